seq_restoring_divider: RTL
==========================

Name: seq_restoring_divider

Overview:
- Sequential restoring divider: 2N-bit unsigned dividend / N-bit unsigned divisor -> 2N-bit quotient + N-bit remainder.
- Inverse of the team's 4x4 array multiplier; same default operand sizing (N=4, 8-bit dividend).
- Produces one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath; its results can be checked against the multiplier (q*d + r = dividend).

Parameters:
- N, 4, divisor and remainder width; dividend and quotient are 2N bits; iteration count = 2N.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  2N  unsigned dividend; captured on the accepting edge.
- divisor  input  N  unsigned divisor; captured on the accepting edge.
- quotient  output  2N  registered result; holds until the next completion.
- remainder  output  N  registered result; holds until the next completion.
- busy  output  1  high while an iteration sequence is in progress.
- done  output  1  single-cycle pulse when quotient/remainder/div_by_zero update.
- div_by_zero  output  1  registered flag; valid with done, holds until the next completion.

Behaviour:
- Reset (rst=1 at an edge):
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - Internal state goes to IDLE; iteration count and working registers are cleared.
  - Reset overrides start and aborts any in-progress operation; no done pulse is produced for an aborted operation.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Accept: at edge k with state IDLE and start=1 (rst=0):
  - Latch the dividend into the shift register and the divisor into the divisor register.
  - Clear the partial remainder (N+1 bits) and the iteration count.
  - If the divisor is nonzero, go to RUN.
- Iteration (each RUN edge, i = 2N-1 down to 0):
  - r = {r[N-1:0], dividend_bit[i]}.
  - If r >= divisor: r = r - divisor and q[i] = 1; otherwise q[i] = 0.
  - The partial remainder is N+1 bits wide; the compare and subtract are N+1 bits wide; no overflow is possible.
- Completion at edge k+2N (the 2N-th iteration edge):
  - quotient and remainder (final r[N-1:0]) load, div_by_zero=0, done=1 for one cycle, state returns to IDLE, busy=0.
  - Latency: busy is high for exactly 2N cycles; done is seen in the cycle after edge k+2N.
- Divide by zero (divisor==0 at accept edge k):
  - No RUN state is entered.
  - At edge k: quotient = all ones, remainder = 0, div_by_zero = 1, done = 1, busy stays 0.
- done is deasserted at every edge that is not a completion edge.
- start while busy=1 is ignored: no latch, no effect on the operation in progress, no queueing.
- start in the same cycle that done=1 is accepted (state is IDLE); done drops on that edge, and a new busy period begins.
- Changes to dividend/divisor after acceptance have no effect on the operation in progress.
- Outputs hold their last result while idle; with no further start, done stays 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Basic division: reset, then start with dividend=200, divisor=7 -> busy high 8 cycles, one-cycle done, quotient=28, remainder=4, div_by_zero=0.
- Limits and zero:
  - 255/1 -> quotient=255, remainder=0.
  - 255/15 -> quotient=17, remainder=0.
  - 0/5 -> quotient=0, remainder=0.
  - 6/9 -> quotient=0, remainder=6.
- Divide by zero: start with dividend=13, divisor=0 -> done and div_by_zero=1 in the cycle after the accept edge, busy never high, quotient=255, remainder=0. The next 100/3 -> quotient=33, remainder=1, div_by_zero=0.
- Busy protection: start 200/7, pulse start with 50/5 on cycle 3 of busy and change the operand inputs -> still quotient=28, remainder=4; exactly one done pulse; no second operation follows.
- Back-to-back and reset:
  - Assert start with 100/3 in the done cycle of 200/7 -> second result quotient=33, remainder=1 after 8 more busy cycles.
  - Separately, assert rst on busy cycle 4 -> all outputs 0, no done pulse; a subsequent 200/7 completes correctly.
- Randomised sweep: exhaustive over all dividend (0-255) and divisor (1-15) -> quotient*divisor + remainder == dividend, remainder < divisor; cross-check the product against the array multiplier.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero completes immediately with an all-ones quotient.
module seq_restoring_divider #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned DW = 2 * N;
    localparam int unsigned RW = N + 1;
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   shf_q, shf_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [N-1:0]    rmd_q, rmd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic [RW-1:0]   rem_sh;
    logic            q_bit;
    logic [N-1:0]    rem_nx;

    // The stored partial remainder is always below the divisor, so its top bit
    // is only needed transiently after the shift-in.
    always_comb begin
        rem_sh = {rem_q, shf_q[DW-1]};
        q_bit  = (rem_sh >= {1'b0, dvs_q});
        rem_nx = q_bit ? N'(rem_sh - {1'b0, dvs_q}) : rem_sh[N-1:0];
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shf_d   = shf_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shf_d = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    if (divisor != '0) begin
                        state_d = RUN;
                    end else begin
                        quo_d  = '1;
                        rmd_d  = '0;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                shf_d = {shf_q[DW-2:0], q_bit};
                rem_d = rem_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    quo_d   = {shf_q[DW-2:0], q_bit};
                    rmd_d   = rem_nx;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shf_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shf_q   <= shf_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
